mic_ibuf: RTL
=============

# mic_ibuf

Instruction byte buffer in the MIC address path, directly downstream of the DC609 ADD chip. It issues longword prefetches at the PC the ADD chip maintains, absorbs the returned memory longwords into an 8-byte circular queue, and presents the oldest 4 bytes to the instruction decoder. A PC load on the ADD chip redirects the stream. The buffer then flushes, and any fetch still in flight is discarded.

## Interface
Parameters:
- IB_BYTES, 8: queue depth in bytes. Fixed; must be a power of two and at least 8.

Ports:
- b_clk_l  in  1  clock; all registers update on its rising edge
- reset_h  in  1  synchronous reset, active-high
- flush_h  in  1  PC redirect; asserted in the same cycle the ADD chip loads PC (ena_pc_l low)
- flush_pc_h  in  2  PC[1:0] of the new stream (ADD pc_h[1:0]); byte offset of the first valid byte
- fetch_req_h  out  1  request for one aligned longword at the current ADD MA
- fetch_ack_h  in  1  memory accepted the request this cycle
- mem_valid_h  in  1  returned longword valid this cycle
- mem_data_h  in  32  returned longword; byte 0 = bits 7:0
- take_h  in  3  bytes consumed by the decoder this cycle, 0..4
- ib_data_h  out  32  oldest 4 queued bytes; byte 0 = oldest
- ib_count_h  out  4  valid bytes in the queue, 0..8
- inc_pc_h  out  1  pulse one cycle after a longword is accepted; drives the ADD incrementer (ici_l low)

## Operation
- Storage: 8×8-bit byte array with 3-bit rd_ptr and wr_ptr, plus a 4-bit count. Pointers wrap modulo 8.
- Fetch state machine:
  - IDLE: fetch_req_h = (count ≤ 4) & ~flush_h. If fetch_ack_h & fetch_req_h, go to WAIT.
  - WAIT: on mem_valid_h, write bytes align..3 of mem_data_h at wr_ptr, advance wr_ptr and count by 4−align, clear align to 0, and go to IDLE.
  - DROP: on mem_valid_h, write nothing and go to IDLE.
- align: a 2-bit register. flush_h loads flush_pc_h. It is cleared after the first successful write.
- Consume: remove min(take_h, count) bytes at rd_ptr. take_h values greater than count are clamped and must not corrupt the pointers. take_h values 5..7 are treated as 4.
- Count arithmetic:
  - count_next = count − taken + written.
  - The take is applied against the pre-write contents, so the same-cycle write and take do not interact.
  - The count ≤ 4 gate on requests guarantees the queue never overflows.
- Flush dominates everything else in its cycle:
  - count, rd_ptr and wr_ptr go to 0; take and write are ignored.
  - align loads flush_pc_h.
  - State transitions: WAIT→DROP, IDLE→IDLE, DROP→DROP.
  - A mem_valid_h in the flush cycle is discarded. If the state was WAIT, the next state is IDLE, not DROP.
- Outputs:
  - ib_data_h byte k = queue[rd_ptr+k] for k < count, otherwise 8'h00.
  - inc_pc_h = registered (written ≠ 0).
- Reset:
  - State IDLE; count, rd_ptr, wr_ptr and align all 0; storage contents need not be cleared.
  - ib_count_h = 0, ib_data_h = 0, fetch_req_h = 0 during the reset cycle, inc_pc_h = 0.
  - Reset mid-WAIT abandons the fetch. A mem_valid_h arriving after reset is ignored, because the state is IDLE.
- mem_valid_h in IDLE is a protocol error and is ignored.

## Timing
- fetch_req_h is combinational from state, count and flush_h. The request is accepted on the edge where fetch_req_h & fetch_ack_h are both high.
- mem_valid_h sampled at edge N puts the data on ib_data_h / ib_count_h after edge N. inc_pc_h is high for the cycle after edge N.
- Minimum loop:
  - Request and ack in cycle 0; data earliest in cycle 1.
  - The next request can be issued in cycle 2, since fetch_req_h is low in WAIT.
  - Sustained fetch rate is one longword per 2 cycles plus memory latency.
- Take: bytes vanish from ib_data_h after the edge at which take_h is sampled.
- Flush: ib_count_h = 0 after the flush edge. fetch_req_h can be high in the following cycle if the state is IDLE.

## Structure
- Package mic_ib_pkg holds:
  - state enum {IB_IDLE, IB_WAIT, IB_DROP}, 2 bits;
  - IB_BYTES = 8 and IB_PTR_W = 3;
  - the byte-lane helper that builds the written-byte mask from align.
- One sub-module, mic_ib_ram: 8×8 byte array with 4 write lanes (lane enable, rotated address) and a 4-byte rotated combinational read port.
- The top level holds the FSM, pointers, count, align and output masking.

## Test plan
- Reset, then fetch with ack; mem_valid_h with 32'h44332211 and align 0 → ib_count_h = 4, ib_data_h = 32'h44332211, inc_pc_h pulses once.
- flush_h with flush_pc_h = 2, fetch, data 32'hDDCCBBAA → ib_count_h = 2, ib_data_h = 32'h0000DDCC. The next longword 32'h88776655 gives ib_count_h = 6 and ib_data_h = 32'h6655DDCC.
- Fill to 8 bytes → fetch_req_h low. take_h = 3 → ib_count_h = 5, fetch_req_h stays low. take_h = 1 → ib_count_h = 4, fetch_req_h high.
- count 2 and take_h = 4 → ib_count_h = 0, pointers consistent. A subsequent fill shows the correct byte order.
- Same cycle: count 4, take_h = 2, mem_valid_h with 4 bytes → ib_count_h = 6, ib_data_h = bytes 2,3 of the old contents followed by the new bytes 0,1.
- Two flush cases:
  - flush_h while in WAIT: the state goes to DROP, and the returning data 32'hFFFFFFFF is discarded with ib_count_h = 0. The next fetch completes normally.
  - flush_h coincident with mem_valid_h: the data is discarded and the state goes to IDLE.

Source files
------------

// File: rtl/mic_ib_pkg.sv
// Shared types and constants for the MIC instruction byte buffer.
package mic_ib_pkg;

  localparam int IB_BYTES = 8;
  localparam int IB_PTR_W = 3;

  typedef enum logic [1:0] {
    IB_IDLE = 2'd0,
    IB_WAIT = 2'd1,
    IB_DROP = 2'd2
  } ib_state_t;

  // Byte lanes of a returned longword that carry stream bytes: lanes align..3.
  function automatic logic [3:0] lane_mask(input logic [1:0] align);
    logic [3:0] mask;
    case (align)
      2'd0:    mask = 4'b1111;
      2'd1:    mask = 4'b1110;
      2'd2:    mask = 4'b1100;
      2'd3:    mask = 4'b1000;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mic_ibuf_if.sv
// Memory-side prefetch bus of the instruction byte buffer.
interface mic_ibuf_if;
  logic        fetch_req_h;
  logic        fetch_ack_h;
  logic        mem_valid_h;
  logic [31:0] mem_data_h;

  modport master (
    output fetch_req_h,
    input  fetch_ack_h,
    input  mem_valid_h,
    input  mem_data_h
  );

  modport slave (
    input  fetch_req_h,
    output fetch_ack_h,
    output mem_valid_h,
    output mem_data_h
  );
endinterface

// File: rtl/mic_ib_ram.sv
// 8x8 byte store: four write lanes at wr_base+lane, four-byte rotated read at rd_ptr.
module mic_ib_ram
  import mic_ib_pkg::*;
(
  input  logic                clk,
  input  logic [3:0]          wr_en,
  input  logic [IB_PTR_W-1:0] wr_base,
  input  logic [31:0]         wr_data,
  input  logic [IB_PTR_W-1:0] rd_ptr,
  output logic [31:0]         rd_data
);

  logic [7:0] mem [IB_BYTES];

  // Write each enabled lane into its rotated byte slot; lane addresses never collide.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) begin
        mem[wr_base + IB_PTR_W'(k)] <= wr_data[8*k +: 8];
      end
    end
  end

  // Present the four bytes starting at rd_ptr, wrapping around the array.
  always_comb begin
    rd_data = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      rd_data[8*k +: 8] = mem[rd_ptr + IB_PTR_W'(k)];
    end
  end

endmodule

// File: rtl/mic_ibuf.sv
// MIC instruction byte buffer: longword prefetch FSM, 8-byte circular queue,
// redirect flush with in-flight fetch discard, and masked 4-byte decoder window.
module mic_ibuf #(
  parameter int IB_BYTES = 8
) (
  input  logic        b_clk_l,
  input  logic        reset_h,
  input  logic        flush_h,
  input  logic [1:0]  flush_pc_h,
  mic_ibuf_if.master  mem,
  input  logic [2:0]  take_h,
  output logic [31:0] ib_data_h,
  output logic [3:0]  ib_count_h,
  output logic        inc_pc_h
);
  import mic_ib_pkg::*;

  ib_state_t           state;
  ib_state_t           state_next;
  logic [3:0]          count;
  logic [IB_PTR_W-1:0] rd_ptr;
  logic [IB_PTR_W-1:0] wr_ptr;
  logic [1:0]          align;
  logic [3:0]          take_clamp;
  logic [3:0]          taken;
  logic [3:0]          written;
  logic                wr_fire;
  logic [3:0]          wr_en;
  logic [IB_PTR_W-1:0] wr_base;
  logic                fetch_req;
  logic [31:0]         rd_data;

  // Take/write amounts for this cycle; the take is clamped to the pre-write count.
  always_comb begin
    take_clamp = (take_h > 3'd4) ? 4'd4 : {1'b0, take_h};
    taken      = (take_clamp > count) ? count : take_clamp;
    wr_fire    = (state == IB_WAIT) && mem.mem_valid_h && !flush_h && !reset_h;
    written    = wr_fire ? (4'd4 - {2'b00, align}) : 4'd0;
    wr_en      = wr_fire ? lane_mask(align) : 4'b0000;
    wr_base    = wr_ptr - {1'b0, align};
  end

  // Request only with room for a full longword, never while redirecting or in reset.
  always_comb begin
    fetch_req = (state == IB_IDLE) && (count <= 4'(IB_BYTES - 4)) && !flush_h && !reset_h;
  end

  assign mem.fetch_req_h = fetch_req;

  // Fetch FSM next state; a flush turns an outstanding fetch into a drop unless data lands now.
  always_comb begin
    state_next = state;
    case (state)
      IB_IDLE: begin
        if (flush_h)                           state_next = IB_IDLE;
        else if (fetch_req && mem.fetch_ack_h) state_next = IB_WAIT;
        else                                   state_next = IB_IDLE;
      end
      IB_WAIT: begin
        if (flush_h)               state_next = mem.mem_valid_h ? IB_IDLE : IB_DROP;
        else if (mem.mem_valid_h)  state_next = IB_IDLE;
        else                       state_next = IB_WAIT;
      end
      IB_DROP: begin
        if (flush_h)               state_next = IB_DROP;
        else if (mem.mem_valid_h)  state_next = IB_IDLE;
        else                       state_next = IB_DROP;
      end
      default: state_next = IB_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge b_clk_l) begin
    if (reset_h) state <= IB_IDLE;
    else         state <= state_next;
  end

  // Queue bookkeeping: flush empties the queue and loads the new stream byte offset.
  always_ff @(posedge b_clk_l) begin
    if (reset_h) begin
      count    <= 4'd0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      align    <= 2'd0;
      inc_pc_h <= 1'b0;
    end else if (flush_h) begin
      count    <= 4'd0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      align    <= flush_pc_h;
      inc_pc_h <= 1'b0;
    end else begin
      count    <= count - taken + written;
      rd_ptr   <= rd_ptr + taken[IB_PTR_W-1:0];
      wr_ptr   <= wr_ptr + written[IB_PTR_W-1:0];
      if (wr_fire) align <= 2'd0;
      inc_pc_h <= wr_fire;
    end
  end

  mic_ib_ram u_ram (
    .clk     (b_clk_l),
    .wr_en   (wr_en),
    .wr_base (wr_base),
    .wr_data (mem.mem_data_h),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  // Decoder window: only valid bytes are shown, everything reads zero during reset.
  always_comb begin
    ib_count_h = reset_h ? 4'd0 : count;
    ib_data_h  = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      if (!reset_h && (count > 4'(k))) ib_data_h[8*k +: 8] = rd_data[8*k +: 8];
      else                             ib_data_h[8*k +: 8] = 8'h00;
    end
  end

endmodule
